csr_file: RTL and testbench

Machine-mode Control and Status Register file for the RV64 core. It is the consumer of the writeback stage's CSR-store and context-switch outputs. It commits CSR instruction writes, performs hardware trap entry and MRET return, and tracks the current privilege level and interrupt enables. It also serves the decode stage's CSR read port and reports pending interrupts and the privilege level back to the pipeline.

---
 rtl/csr_pkg.sv | 68 ++++++
 rtl/csr_file_if.sv | 38 +++
 rtl/csr_counter.sv | 37 +++
 rtl/csr_file.sv | 244 ++++++++++++++++++++++++
 tb/tb_csr_file.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, field positions, encodings and WARL helpers for csr_file
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    localparam int MIE_MTIE_BIT = 7;
    localparam int MIE_MEIE_BIT = 11;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    localparam logic [1:0] MPP_U = 2'b00;
    localparam logic [1:0] MPP_M = 2'b11;

    typedef enum logic {
        PRIV_U = 1'b0,
        PRIV_M = 1'b1
    } priv_e;

    // MXL = 2 (64-bit) in the top two bits, extension letter I at bit 8
    localparam logic [63:0] MISA_RV64I = 64'h8000_0000_0000_0100;

    // Only U and M exist, so the reserved S/H encodings collapse to U
    function automatic logic [1:0] warl_mpp(input logic [1:0] v);
        return ((v == 2'b01) || (v == 2'b10)) ? MPP_U : v;
    endfunction

    // Reserved vector modes collapse to direct
    function automatic logic [1:0] warl_mtvec_mode(input logic [1:0] v);
        return (v[1]) ? MTVEC_MODE_DIRECT : v;
    endfunction

    function automatic logic csr_implemented(input logic [11:0] a);
        case (a)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE,
            CSR_MINSTRET, CSR_MHARTID: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic csr_writable(input logic [11:0] a);
        case (a)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE, CSR_MINSTRET: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - pipeline-to-CSR-file signal bundle with pipeline (master) and CSR (slave) views
interface csr_file_if #(
    parameter int XLEN = 64
);
    logic            WB_ST_CSR;
    logic [11:0]     WB_CSR_ADDR;
    logic [XLEN-1:0] WB_CSR_DATA;
    logic            WB_CS;
    logic [XLEN-1:0] WB_CAUSE;
    logic [XLEN-1:0] WB_PC;
    logic [XLEN-1:0] WB_TVAL;
    logic            WB_MRET;
    logic            WB_V;
    logic            TIMER;
    logic            EXTERNAL;
    logic [11:0]     DE_CSR_ADDR;
    logic [XLEN-1:0] DE_CSRFD;
    logic            DE_CSR_ILLEGAL;
    logic            CSR_REDIRECT;
    logic [XLEN-1:0] CSR_TARGET;
    logic            PRIVILEGE;
    logic            INT_TIMER;
    logic            INT_EXTERNAL;

    modport master (
        output WB_ST_CSR, WB_CSR_ADDR, WB_CSR_DATA, WB_CS, WB_CAUSE, WB_PC, WB_TVAL,
               WB_MRET, WB_V, TIMER, EXTERNAL, DE_CSR_ADDR,
        input  DE_CSRFD, DE_CSR_ILLEGAL, CSR_REDIRECT, CSR_TARGET, PRIVILEGE,
               INT_TIMER, INT_EXTERNAL
    );

    modport slave (
        input  WB_ST_CSR, WB_CSR_ADDR, WB_CSR_DATA, WB_CS, WB_CAUSE, WB_PC, WB_TVAL,
               WB_MRET, WB_V, TIMER, EXTERNAL, DE_CSR_ADDR,
        output DE_CSRFD, DE_CSR_ILLEGAL, CSR_REDIRECT, CSR_TARGET, PRIVILEGE,
               INT_TIMER, INT_EXTERNAL
    );
endinterface

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - free-running counter with software write taking priority over increment
module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // A write replaces the count outright; otherwise step by one, wrapping silently
    always_comb begin
        count_d = count_q;
        if (we_i) begin
            count_d = wdata_i;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file: writes, trap entry, MRET, privilege, interrupts, counters
module csr_file
    import csr_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int HARTID = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    csr_file_if.slave   bus
);

    logic do_trap;
    logic do_mret;
    logic do_write;

    // Trap beats MRET beats CSR write; losers have no effect at all
    assign do_trap  = bus.WB_CS;
    assign do_mret  = bus.WB_MRET & ~bus.WB_CS;
    assign do_write = bus.WB_ST_CSR & ~bus.WB_CS & ~bus.WB_MRET;

    priv_e           priv_q, priv_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [1:0]      mpp_q, mpp_d;
    logic            mtie_q, mtie_d;
    logic            meie_q, meie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;

    logic [XLEN-1:0] wdata;
    logic [11:0]     waddr;

    assign wdata = bus.WB_CSR_DATA;
    assign waddr = bus.WB_CSR_ADDR;

    // Privilege FSM: leave M only via MRET to a U-mode MPP; leave U only via a trap
    always_comb begin
        priv_d = priv_q;
        case (priv_q)
            PRIV_M: begin
                if (do_mret && (mpp_q == MPP_U)) begin
                    priv_d = PRIV_U;
                end
            end
            PRIV_U: begin
                if (do_trap) begin
                    priv_d = PRIV_M;
                end
            end
            default: priv_d = PRIV_M;
        endcase
    end

    // Next-state for the architectural registers: trap, else MRET, else CSR write
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mpp_d      = mpp_q;
        mtie_d     = mtie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (do_trap) begin
            mepc_d   = {bus.WB_PC[XLEN-1:2], 2'b00};
            mcause_d = bus.WB_CAUSE;
            mtval_d  = bus.WB_TVAL;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = {2{priv_q == PRIV_M}};
        end else if (do_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            mpp_d  = MPP_U;
        end else if (do_write) begin
            case (waddr)
                CSR_MSTATUS: begin
                    mie_d  = wdata[MSTATUS_MIE_BIT];
                    mpie_d = wdata[MSTATUS_MPIE_BIT];
                    mpp_d  = warl_mpp(wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
                end
                CSR_MIE: begin
                    mtie_d = wdata[MIE_MTIE_BIT];
                    meie_d = wdata[MIE_MEIE_BIT];
                end
                CSR_MTVEC:    mtvec_d    = {wdata[XLEN-1:2], warl_mtvec_mode(wdata[1:0])};
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = {wdata[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wdata;
                CSR_MTVAL:    mtval_d    = wdata;
                default: ;
            endcase
        end
    end

    // Architectural state registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            priv_q     <= PRIV_M;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mpp_q      <= MPP_U;
            mtie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            priv_q     <= priv_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mpp_q      <= mpp_d;
            mtie_q     <= mtie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    csr_counter #(.WIDTH(XLEN)) u_mcycle (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (do_write && (waddr == CSR_MCYCLE)),
        .wdata_i (wdata),
        .inc_i   (1'b1),
        .count_o (mcycle)
    );

    csr_counter #(.WIDTH(XLEN)) u_minstret (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (do_write && (waddr == CSR_MINSTRET)),
        .wdata_i (wdata),
        .inc_i   (bus.WB_V & ~bus.WB_CS),
        .count_o (minstret)
    );

    logic [XLEN-1:0] reg_view;
    logic [XLEN-1:0] wr_view;
    logic [XLEN-1:0] rd_val;
    logic            bypass_hit;
    logic            rd_illegal;

    // Read value of the committed registers at the decode address
    always_comb begin
        reg_view = '0;
        case (bus.DE_CSR_ADDR)
            CSR_MSTATUS: begin
                reg_view[MSTATUS_MIE_BIT]                 = mie_q;
                reg_view[MSTATUS_MPIE_BIT]                = mpie_q;
                reg_view[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = mpp_q;
            end
            CSR_MISA: reg_view = MISA_RV64I;
            CSR_MIE: begin
                reg_view[MIE_MTIE_BIT] = mtie_q;
                reg_view[MIE_MEIE_BIT] = meie_q;
            end
            CSR_MTVEC:    reg_view = mtvec_q;
            CSR_MSCRATCH: reg_view = mscratch_q;
            CSR_MEPC:     reg_view = mepc_q;
            CSR_MCAUSE:   reg_view = mcause_q;
            CSR_MTVAL:    reg_view = mtval_q;
            CSR_MIP: begin
                reg_view[MIP_MTIP_BIT] = bus.TIMER;
                reg_view[MIP_MEIP_BIT] = bus.EXTERNAL;
            end
            CSR_MCYCLE:   reg_view = mcycle;
            CSR_MINSTRET: reg_view = minstret;
            CSR_MHARTID:  reg_view = XLEN'(HARTID);
            default:      reg_view = '0;
        endcase
    end

    // What the register will read once the in-flight WB write lands, WARL applied
    always_comb begin
        wr_view = wdata;
        case (waddr)
            CSR_MSTATUS: begin
                wr_view                                  = '0;
                wr_view[MSTATUS_MIE_BIT]                 = wdata[MSTATUS_MIE_BIT];
                wr_view[MSTATUS_MPIE_BIT]                = wdata[MSTATUS_MPIE_BIT];
                wr_view[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = warl_mpp(wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
            end
            CSR_MIE: begin
                wr_view               = '0;
                wr_view[MIE_MTIE_BIT] = wdata[MIE_MTIE_BIT];
                wr_view[MIE_MEIE_BIT] = wdata[MIE_MEIE_BIT];
            end
            CSR_MTVEC: wr_view = {wdata[XLEN-1:2], warl_mtvec_mode(wdata[1:0])};
            CSR_MEPC:  wr_view = {wdata[XLEN-1:2], 2'b00};
            default:   wr_view = wdata;
        endcase
    end

    // Decode read port with same-cycle write bypass and illegal-access squash
    always_comb begin
        bypass_hit = do_write && (waddr == bus.DE_CSR_ADDR) && csr_writable(waddr);
        rd_illegal = !csr_implemented(bus.DE_CSR_ADDR) || (priv_q == PRIV_U);
        rd_val     = bypass_hit ? wr_view : reg_view;
        if (rd_illegal) begin
            rd_val = '0;
        end
    end

    assign bus.DE_CSRFD       = rd_val;
    assign bus.DE_CSR_ILLEGAL = rd_illegal;

    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    // Vectored mode only offsets asynchronous causes; exceptions still go to BASE
    always_comb begin
        trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
        trap_target = trap_base;
        if ((mtvec_q[1:0] == MTVEC_MODE_VECTORED) && bus.WB_CAUSE[XLEN-1]) begin
            trap_target = trap_base + {{(XLEN-8){1'b0}}, bus.WB_CAUSE[5:0], 2'b00};
        end
    end

    assign bus.CSR_REDIRECT = (bus.WB_CS | bus.WB_MRET) & ~RESET;
    assign bus.CSR_TARGET   = bus.WB_CS ? trap_target : (bus.WB_MRET ? mepc_q : '0);
    assign bus.PRIVILEGE    = (priv_q == PRIV_M);

    logic int_enable;

    // U-mode code can always be interrupted into M; in M the global MIE gates
    assign int_enable       = mie_q | (priv_q == PRIV_U);
    assign bus.INT_TIMER    = bus.TIMER & mtie_q & int_enable & ~RESET;
    assign bus.INT_EXTERNAL = bus.EXTERNAL & meie_q & int_enable & ~RESET;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed self-checking bench for csr_file
module tb_csr_file;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    csr_file_if #(.XLEN(64)) bus ();

    csr_file #(.XLEN(64), .HARTID(0)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
        bus.DE_CSR_ADDR = a;
        #1;
        chk(tag, bus.DE_CSRFD, exp);
        chk({tag, "_ill"}, {63'd0, bus.DE_CSR_ILLEGAL}, 64'd0);
    endtask

    task automatic chk_ill(input string tag, input logic [11:0] a);
        bus.DE_CSR_ADDR = a;
        #1;
        chk(tag, {63'd0, bus.DE_CSR_ILLEGAL}, 64'd1);
        chk({tag, "_data"}, bus.DE_CSRFD, 64'd0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        bus.WB_ST_CSR   = 1'b1;
        bus.WB_CSR_ADDR = a;
        bus.WB_CSR_DATA = d;
        tick();
        bus.WB_ST_CSR   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        bus.WB_ST_CSR   = 1'b0;
        bus.WB_CSR_ADDR = '0;
        bus.WB_CSR_DATA = '0;
        bus.WB_CS       = 1'b0;
        bus.WB_CAUSE    = '0;
        bus.WB_PC       = '0;
        bus.WB_TVAL     = '0;
        bus.WB_MRET     = 1'b0;
        bus.WB_V        = 1'b0;
        bus.TIMER       = 1'b1;
        bus.EXTERNAL    = 1'b1;
        bus.DE_CSR_ADDR = '0;

        // Reset asserted together with a trap: no redirect
        rst         = 1'b1;
        bus.WB_CS   = 1'b1;
        bus.WB_PC   = 64'h4444;
        #1;
        chk("rst_redirect", {63'd0, bus.CSR_REDIRECT}, 64'd0);
        tick();
        bus.WB_CS = 1'b0;
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_priv", {63'd0, bus.PRIVILEGE}, 64'd1);
        chk("rst_int_t", {63'd0, bus.INT_TIMER}, 64'd0);
        chk_rd("rst_mstatus", 12'h300, 64'd0);
        chk_rd("rst_mcycle", 12'hB00, 64'd0);
        chk_rd("rst_mepc", 12'h341, 64'd0);
        chk_ill("unimpl_7c0", 12'h7C0);
        chk_rd("misa", 12'h301, 64'h8000_0000_0000_0100);
        tick();
        chk_rd("mhartid", 12'hF14, 64'd0);
        chk_rd("mip", 12'h344, 64'h880);

        // mstatus.MIE = 1 with same-cycle bypass, then mtvec vectored
        bus.WB_ST_CSR   = 1'b1;
        bus.WB_CSR_ADDR = 12'h300;
        bus.WB_CSR_DATA = 64'h8;
        chk_rd("bypass_mstatus", 12'h300, 64'h8);
        tick();
        bus.WB_ST_CSR = 1'b0;
        wr(12'h305, 64'h8000_0001);
        chk_rd("mtvec", 12'h305, 64'h8000_0001);

        // Vectored interrupt trap
        bus.WB_CS    = 1'b1;
        bus.WB_CAUSE = 64'h8000_0000_0000_0007;
        bus.WB_PC    = 64'h1000;
        bus.WB_TVAL  = 64'h55;
        #1;
        chk("trap_redirect", {63'd0, bus.CSR_REDIRECT}, 64'd1);
        chk("trap_target", bus.CSR_TARGET, 64'h8000_001C);
        tick();
        bus.WB_CS = 1'b0;
        chk_rd("trap_mepc", 12'h341, 64'h1000);
        chk_rd("trap_mcause", 12'h342, 64'h8000_0000_0000_0007);
        chk_rd("trap_mtval", 12'h343, 64'h55);
        chk_rd("trap_mstatus", 12'h300, 64'h1880);
        chk("trap_priv", {63'd0, bus.PRIVILEGE}, 64'd1);

        // MRET to U-mode
        wr(12'h300, 64'h0);
        wr(12'h341, 64'h2003);
        chk_rd("mepc_align", 12'h341, 64'h2000);
        bus.WB_MRET = 1'b1;
        #1;
        chk("mret_redirect", {63'd0, bus.CSR_REDIRECT}, 64'd1);
        chk("mret_target", bus.CSR_TARGET, 64'h2000);
        tick();
        bus.WB_MRET = 1'b0;
        chk("mret_priv", {63'd0, bus.PRIVILEGE}, 64'd0);
        chk_ill("umode_mepc", 12'h341);

        // Trap, MRET and write together: trap wins, exception goes to BASE
        bus.WB_CS       = 1'b1;
        bus.WB_MRET     = 1'b1;
        bus.WB_ST_CSR   = 1'b1;
        bus.WB_CSR_ADDR = 12'h340;
        bus.WB_CSR_DATA = 64'd5;
        bus.WB_CAUSE    = 64'd2;
        bus.WB_PC       = 64'h3000;
        bus.WB_TVAL     = 64'd0;
        #1;
        chk("triple_target", bus.CSR_TARGET, 64'h8000_0000);
        tick();
        bus.WB_CS     = 1'b0;
        bus.WB_MRET   = 1'b0;
        bus.WB_ST_CSR = 1'b0;
        chk("triple_priv", {63'd0, bus.PRIVILEGE}, 64'd1);
        chk_rd("triple_mscratch", 12'h340, 64'd0);
        chk_rd("triple_mepc", 12'h341, 64'h3000);
        chk_rd("triple_mstatus", 12'h300, 64'h0);
        chk_rd("triple_mcause", 12'h342, 64'd2);

        // Interrupt gating
        wr(12'h304, 64'h80);
        chk("int_t_mie0", {63'd0, bus.INT_TIMER}, 64'd0);
        chk("int_e_meie0", {63'd0, bus.INT_EXTERNAL}, 64'd0);
        chk_rd("mie_rd", 12'h304, 64'h80);
        wr(12'h300, 64'h8);
        chk("int_t_mie1", {63'd0, bus.INT_TIMER}, 64'd1);
        chk_rd("mstatus_mie1", 12'h300, 64'h8);

        // WARL
        bus.WB_ST_CSR   = 1'b1;
        bus.WB_CSR_ADDR = 12'h300;
        bus.WB_CSR_DATA = 64'h1088;
        chk_rd("warl_mpp_bypass", 12'h300, 64'h88);
        tick();
        bus.WB_ST_CSR = 1'b0;
        chk_rd("warl_mpp", 12'h300, 64'h88);
        wr(12'h305, 64'h8000_0003);
        chk_rd("warl_mtvec", 12'h305, 64'h8000_0000);
        wr(12'h301, 64'd0);
        chk_rd("misa_ro", 12'h301, 64'h8000_0000_0000_0100);
        wr(12'hF14, 64'd9);
        chk_rd("hartid_ro", 12'hF14, 64'd0);

        // minstret wrap, write priority, trap suppresses increment
        wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        chk_rd("minstret_max", 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.WB_V = 1'b1;
        tick();
        bus.WB_V = 1'b0;
        chk_rd("minstret_wrap", 12'hB02, 64'd0);
        bus.WB_V = 1'b1;
        wr(12'hB02, 64'd5);
        bus.WB_V = 1'b0;
        chk_rd("minstret_wr_wins", 12'hB02, 64'd5);
        bus.WB_V     = 1'b1;
        bus.WB_CS    = 1'b1;
        bus.WB_CAUSE = 64'd0;
        tick();
        bus.WB_V  = 1'b0;
        bus.WB_CS = 1'b0;
        chk_rd("minstret_cs", 12'hB02, 64'd5);

        // mcycle write then increment
        wr(12'hB00, 64'd10);
        chk_rd("mcycle_wr", 12'hB00, 64'd10);
        tick();
        chk_rd("mcycle_inc", 12'hB00, 64'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
